dac_serializer: RTL and testbench

- Transmit-side stage for the WM8731 DAC path.
- Accepts parallel left/right sample pairs through a valid/ready handshake and generates m_clk, b_clk, dac_lr_clk and dacdat.
- Output format: each dac_lr_clk rise starts a frame of left then right, MSB first, valid on the falling edge of b_clk.
- Directly feeds the codec pins and the bench-side DAC functional model that deserializes this stream.

---
 rtl/dac_serializer.sv | 132 +++++++++++++
 tb/tb_dac_serializer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_serializer.sv
// WM8731 DAC transmit stage: divides clk into m_clk/b_clk, frames left/right
// sample pairs MSB first, with data launched on b_clk rising edges.
module dac_serializer #(
  parameter int SAMPLE_BITS = 16,
  parameter int MCLK_HALF   = 2,
  parameter int BCLK_HALF   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SAMPLE_BITS-1:0] in_left,
  input  logic [SAMPLE_BITS-1:0] in_right,
  output logic                   m_clk,
  output logic                   b_clk,
  output logic                   dac_lr_clk,
  output logic                   dacdat,
  output logic                   underrun
);

  localparam int FRAME_BITS = 2 * SAMPLE_BITS;
  localparam int MW = $clog2(MCLK_HALF + 1);
  localparam int BW = $clog2(BCLK_HALF + 1);
  localparam int IW = $clog2(FRAME_BITS);

  localparam logic [MW-1:0] MTERM      = MW'(MCLK_HALF - 1);
  localparam logic [BW-1:0] BTERM      = BW'(BCLK_HALF - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(FRAME_BITS - 1);
  localparam logic [IW-1:0] IDX_RIGHT  = IW'(SAMPLE_BITS);

  typedef struct packed {
    logic [SAMPLE_BITS-1:0] left;
    logic [SAMPLE_BITS-1:0] right;
  } pair_t;

  logic [MW-1:0]         mcnt;
  logic [BW-1:0]         bcnt;
  logic [IW-1:0]         bidx;
  logic [FRAME_BITS-1:0] shifter;
  pair_t                 hold;
  logic                  accept;
  logic                  tick;
  logic                  frame_start;
  logic                  right_start;

  assign accept      = in_valid && in_ready;
  // A bit tick is the divider terminal count that drives b_clk high.
  assign tick        = enable && (bcnt == BTERM) && !b_clk;
  assign frame_start = tick && (bidx == '0);
  assign right_start = tick && (bidx == IDX_RIGHT);

  // Codec master clock: free running, unaffected by enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt  <= '0;
      m_clk <= 1'b0;
    end else if (mcnt == MTERM) begin
      mcnt  <= '0;
      m_clk <= ~m_clk;
    end else begin
      mcnt  <= mcnt + 1'b1;
    end
  end

  // Holding register; in_ready doubles as the "empty" flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b1;
      hold     <= '0;
    end else if (frame_start && !in_ready) begin
      in_ready <= 1'b1;
    end else if (accept) begin
      in_ready   <= 1'b0;
      hold.left  <= in_left;
      hold.right <= in_right;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else begin
      underrun <= frame_start && in_ready;
    end
  end

  // Bit clock, frame index and shifter; dropping enable discards the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt       <= '0;
      b_clk      <= 1'b0;
      bidx       <= '0;
      shifter    <= '0;
      dac_lr_clk <= 1'b0;
      dacdat     <= 1'b0;
    end else if (!enable) begin
      bcnt       <= '0;
      b_clk      <= 1'b0;
      bidx       <= '0;
      shifter    <= '0;
      dac_lr_clk <= 1'b0;
      dacdat     <= 1'b0;
    end else begin
      if (bcnt == BTERM) begin
        bcnt  <= '0;
        b_clk <= ~b_clk;
      end else begin
        bcnt  <= bcnt + 1'b1;
      end
      if (tick) begin
        bidx <= (bidx == IDX_LAST) ? '0 : bidx + 1'b1;
        if (frame_start) begin
          dac_lr_clk <= 1'b1;
          if (!in_ready) begin
            shifter <= hold;
            dacdat  <= hold.left[SAMPLE_BITS-1];
          end else begin
            shifter <= '0;
            dacdat  <= 1'b0;
          end
        end else begin
          // MSB was launched at load, so each later tick emits the next bit down.
          shifter <= shifter << 1;
          dacdat  <= shifter[FRAME_BITS-2];
          if (right_start) dac_lr_clk <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_serializer.sv
// Bench for dac_serializer: a pin-level deserializer rebuilds frames from
// b_clk falls and they are compared against a queue of expected sample pairs.
module tb_dac_serializer;
  localparam int SB = 16;
  localparam int MH = 2;
  localparam int BH = 8;
  localparam int FB = 2 * SB;
  localparam int TH = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          in_valid = 1'b0;
  logic [SB-1:0] in_left = '0;
  logic [SB-1:0] in_right = '0;
  logic          in_ready, m_clk, b_clk, dac_lr_clk, dacdat, underrun;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [FB-1:0] data;
    logic          urun;
    logic          rdy;
  } frame_t;

  frame_t got[$];
  frame_t expq[$];

  dac_serializer #(.SAMPLE_BITS(SB), .MCLK_HALF(MH), .BCLK_HALF(BH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
    .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
    .m_clk(m_clk), .b_clk(b_clk), .dac_lr_clk(dac_lr_clk),
    .dacdat(dacdat), .underrun(underrun)
  );

  always #TH clk = ~clk;

  // Codec-side deserializer and rate monitor.
  logic   pm = 1'b0, pb = 1'b0, plr = 1'b0;
  longint tm_rise = 0, tm_per = 0, tb_rise = 0, tb_per = 0;
  longint lr_rise = 0, lr_per = 0, lr_high = 0;
  int     nbits = 0;
  int     stray = 0;
  bit     in_frame = 0;
  frame_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0;
      nbits    = 0;
    end else begin
      if (m_clk && !pm) begin
        if (tm_rise != 0) tm_per = $time - tm_rise;
        tm_rise = $time;
      end
      if (b_clk && !pb) begin
        if (tb_rise != 0) tb_per = $time - tb_rise;
        tb_rise = $time;
      end
      if (dac_lr_clk && !plr) begin
        if (lr_rise != 0) lr_per = $time - lr_rise;
        lr_rise  = $time;
        in_frame = 1;
        nbits    = 0;
        cur.data = '0;
        cur.urun = underrun;
        cur.rdy  = in_ready;
      end else if (underrun) begin
        stray++;
      end
      if (!dac_lr_clk && plr) lr_high = $time - lr_rise;
      if (!b_clk && pb && in_frame) begin
        if (nbits < FB) cur.data[FB-1-nbits] = dacdat;
        nbits++;
        if (nbits == FB) got.push_back(cur);
      end
    end
    pm  = m_clk;
    pb  = b_clk;
    plr = dac_lr_clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic frame_t pair_frame(input logic [SB-1:0] l, input logic [SB-1:0] r);
    frame_t f;
    f.data = {l, r};
    f.urun = 1'b0;
    f.rdy  = 1'b1;
    return f;
  endfunction

  function automatic frame_t empty_frame();
    frame_t f;
    f.data = '0;
    f.urun = 1'b1;
    f.rdy  = 1'b1;
    return f;
  endfunction

  // Leaves in_valid high; the caller drops it after the last pair.
  task automatic push(input logic [SB-1:0] l, input logic [SB-1:0] r);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    for (k = 0; k < 3000 && !in_ready; k++) @(negedge clk);
    chk("push_ready_seen", in_ready, 1);
    @(negedge clk);
    chk("push_ready_low", in_ready, 0);
    expq.push_back(pair_frame(l, r));
  endtask

  task automatic wait_frames(input int n);
    int k;
    for (k = 0; k < (n + 1) * FB * 2 * BH + 100 && got.size() < n; k++) @(negedge clk);
    chk("wait_frames", got.size() >= n, 1);
  endtask

  task automatic check_frames(input string tag);
    frame_t e, g;
    chk({tag, "_count"}, got.size(), expq.size());
    while (expq.size() > 0 && got.size() > 0) begin
      e = expq.pop_front();
      g = got.pop_front();
      chk({tag, "_data"}, g.data, e.data);
      chk({tag, "_underrun"}, g.urun, e.urun);
      if (!e.urun) chk({tag, "_ready_at_start"}, g.rdy, 1);
    end
  endtask

  task automatic restart();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    got.delete();
    expq.delete();
    stray = 0;
  endtask

  initial begin
    int k;
    logic [SB-1:0] al, ar, bl, br;

    // Async reset with no clk edge.
    #5 rst_n = 1'b0;
    #1;
    chk("rst_m_clk", m_clk, 0);
    chk("rst_b_clk", b_clk, 0);
    chk("rst_lr", dac_lr_clk, 0);
    chk("rst_dacdat", dacdat, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // m_clk runs while idle; b_clk stays low.
    repeat (20) @(negedge clk);
    chk("m_clk_period", tm_per, 4 * MH * TH);
    chk("idle_b_clk", b_clk, 0);

    // Single pair then two underrun frames.
    restart();
    push(16'hA5C3, 16'h0F01);
    in_valid = 1'b0;
    enable   = 1'b1;
    expq.push_back(empty_frame());
    expq.push_back(empty_frame());
    wait_frames(3);
    check_frames("data");
    chk("b_clk_period", tb_per, 4 * BH * TH);
    chk("lr_period", lr_per, FB * 4 * BH * TH);
    chk("lr_high", lr_high, SB * 4 * BH * TH);
    chk("no_stray_underrun", stray, 0);

    // Back-to-back pairs, directed then random, followed by one underrun.
    restart();
    push(16'h1111, 16'h2222);
    enable = 1'b1;
    push(16'h3333, 16'h4444);
    push(16'h5555, 16'h6666);
    for (int i = 0; i < 3; i++) push(SB'($urandom), SB'($urandom));
    in_valid = 1'b0;
    expq.push_back(empty_frame());
    wait_frames(7);
    check_frames("b2b");
    chk("b2b_stray_underrun", stray, 0);

    // Abort at bit index 20, the held pair goes out on re-enable.
    restart();
    al = SB'($urandom);
    ar = SB'($urandom) | 16'h0800;
    bl = SB'($urandom);
    br = SB'($urandom);
    push(al, ar);
    in_valid = 1'b0;
    enable   = 1'b1;
    for (k = 0; k < 4 * BH && !dac_lr_clk; k++) @(negedge clk);
    chk("abort_frame_started", dac_lr_clk, 1);
    expq.delete();
    push(bl, br);
    in_valid = 1'b0;
    for (k = 0; k < 60 * BH && !(in_frame && nbits >= 20); k++) @(negedge clk);
    for (k = 0; k < 4 * BH && !b_clk; k++) @(negedge clk);
    chk("abort_pre_dacdat", dacdat, ar[SB-5]);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_b_clk", b_clk, 0);
    chk("abort_lr", dac_lr_clk, 0);
    chk("abort_dacdat", dacdat, 0);
    @(negedge clk);
    got.delete();
    enable = 1'b1;
    for (k = 1; k <= 4 * BH; k++) begin
      @(posedge clk);
      #1;
      if (dac_lr_clk) break;
    end
    chk("abort_relaunch_clks", k, BH);
    wait_frames(1);
    check_frames("abort");

    // Reset mid-frame loses the held pair.
    push(16'hBEEF, 16'hCAFE);
    in_valid = 1'b0;
    for (k = 0; k < 70 * BH && !(in_frame && nbits >= 10); k++) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_m_clk", m_clk, 0);
    chk("midrst_b_clk", b_clk, 0);
    chk("midrst_lr", dac_lr_clk, 0);
    chk("midrst_dacdat", dacdat, 0);
    chk("midrst_underrun", underrun, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    got.delete();
    expq.delete();
    expq.push_back(empty_frame());
    wait_frames(1);
    check_frames("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
